// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory-side controller and its RAM.
package mem_pkg;

  localparam int unsigned DefAddrWidth  = 9;
  localparam int unsigned DefDataWidth  = 32;
  localparam int unsigned MaxWaitStates = 15;
  localparam int unsigned CntWidth      = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StDone
  } state_e;

  typedef enum logic {
    OpRead,
    OpWrite
  } op_e;

endpackage

// File: rtl/ram_sp.sv
// Synchronous single-port RAM with a registered read port; the array has no reset.
module ram_sp #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];

  // Read-before-write: dout returns the old word when we and the read hit the same address.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/mem_controller.sv
// MAR plus a wait-stated single-port RAM; returns read data on Mdatain with a one-cycle Done.
module mem_controller
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  MARin,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic [DATA_WIDTH-1:0] mdr_in,
  input  logic                  Read,
  input  logic                  Write,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  Done,
  output logic                  busy,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mar_q
);

  if (WAIT_STATES > MaxWaitStates) begin : gen_bad_wait
    $error("WAIT_STATES must be 0..15");
  end
  if (DATA_WIDTH <= ADDR_WIDTH) begin : gen_bad_width
    $error("DATA_WIDTH must exceed ADDR_WIDTH");
  end

  localparam logic [CntWidth-1:0] WaitInit = CntWidth'(WAIT_STATES);

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  op_e                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] mdatain_q;
  logic                  done_q, busy_q, err_q;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_dout;

  logic unused_bus;
  assign unused_bus = ^bus_in[DATA_WIDTH-1:ADDR_WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ram_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Read ^ Write) begin
          op_d    = Write ? OpWrite : OpRead;
          addr_d  = mar_q;
          wdata_d = mdr_in;
          cnt_d   = WaitInit;
          state_d = (WAIT_STATES == 0) ? StAccess : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CntWidth'(1)) begin
          state_d = StAccess;
        end
      end
      StAccess: begin
        ram_we  = (op_q == OpWrite);
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // In IDLE the RAM reads MAR so a zero-wait-state read still has dout ready on the ACCESS exit
  // edge; otherwise it reads the latched address one cycle ahead of that edge.
  assign ram_addr = (state_q == StIdle) ? mar_q : addr_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= OpRead;
      addr_q    <= '0;
      wdata_q   <= '0;
      mar_q     <= '0;
      mdatain_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (MARin) begin
        mar_q <= bus_in[ADDR_WIDTH-1:0];
      end
      if (state_q == StAccess && op_q == OpRead) begin
        mdatain_q <= ram_dout;
      end
      done_q <= (state_d == StDone);
      busy_q <= (state_d != StIdle);
      err_q  <= (state_q == StIdle) && Read && Write;
    end
  end

  ram_sp #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clock(clock),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (wdata_q),
    .dout (ram_dout)
  );

  assign Mdatain = mdatain_q;
  assign Done    = done_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: a default 2-wait-state instance and a zero-wait-state one.
module tb_mem_controller;

  logic        clock = 1'b0;
  logic        clear = 1'b0;

  logic        a_marin = 1'b0, a_read = 1'b0, a_write = 1'b0;
  logic [31:0] a_bus = '0, a_mdr = '0;
  logic [31:0] a_mdatain;
  logic        a_done, a_busy, a_err;
  logic [8:0]  a_mar;

  logic        b_marin = 1'b0, b_read = 1'b0, b_write = 1'b0;
  logic [31:0] b_bus = '0, b_mdr = '0;
  logic [31:0] b_mdatain;
  logic        b_done, b_busy, b_err;
  logic [8:0]  b_mar;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_controller #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(2)) dut_a (
    .clock(clock), .clear(clear), .MARin(a_marin), .bus_in(a_bus), .mdr_in(a_mdr),
    .Read(a_read), .Write(a_write), .Mdatain(a_mdatain), .Done(a_done), .busy(a_busy),
    .err(a_err), .mar_q(a_mar)
  );

  mem_controller #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(0)) dut_b (
    .clock(clock), .clear(clear), .MARin(b_marin), .bus_in(b_bus), .mdr_in(b_mdr),
    .Read(b_read), .Write(b_write), .Mdatain(b_mdatain), .Done(b_done), .busy(b_busy),
    .err(b_err), .mar_q(b_mar)
  );

  // Stimulus helpers: called and returning at a negedge; they make no comparisons.
  task automatic set_mar(input bit sel, input logic [31:0] v);
    if (sel) begin b_marin = 1'b1; b_bus = v; end
    else     begin a_marin = 1'b1; a_bus = v; end
    @(posedge clock); @(negedge clock);
    a_marin = 1'b0; b_marin = 1'b0;
  endtask

  task automatic run_req(input bit sel, input logic rd, input logic wr, input logic [31:0] wd,
                         output int lat);
    lat = -1;
    if (sel) begin b_mdr = wd; b_read = rd; b_write = wr; end
    else     begin a_mdr = wd; a_read = rd; a_write = wr; end
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); @(negedge clock);
      if ((sel ? b_done : a_done) === 1'b1) begin lat = i; break; end
    end
    a_read = 1'b0; a_write = 1'b0; b_read = 1'b0; b_write = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({a_busy, a_done, a_err, a_mdatain, a_mar} !== '0) begin
      errors++;
      $display("FAIL reset_a: got busy=%b done=%b err=%b mdatain=%h mar=%h, want all zero",
               a_busy, a_done, a_err, a_mdatain, a_mar);
    end
    checks++;
    if ({b_busy, b_done, b_err, b_mdatain, b_mar} !== '0) begin
      errors++;
      $display("FAIL reset_b: got busy=%b done=%b err=%b mdatain=%h mar=%h, want all zero",
               b_busy, b_done, b_err, b_mdatain, b_mar);
    end
    clear = 1'b1;
    @(posedge clock); @(negedge clock);
    checks++;
    if (a_busy !== 1'b0) begin
      errors++; $display("FAIL reset_release_busy: got %b want 0", a_busy);
    end
  endtask

  task automatic test_write_read();
    int lat;
    set_mar(0, 32'h0000_00A5);
    checks++;
    if (a_mar !== 9'h0A5) begin errors++; $display("FAIL mar_load: got %h want 0a5", a_mar); end
    a_mdr = 32'hDEAD_BEEF; a_write = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock); @(negedge clock);
      checks++;
      if (a_busy !== 1'b1 || a_done !== (i == 4)) begin
        errors++;
        $display("FAIL write_seq[%0d]: got busy=%b done=%b want busy=1 done=%b",
                 i, a_busy, a_done, (i == 4));
      end
    end
    a_write = 1'b0;
    @(posedge clock); @(negedge clock);
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0) begin
      errors++; $display("FAIL write_end: got busy=%b done=%b want 0 0", a_busy, a_done);
    end
    checks++;
    if (a_mdatain !== 32'h0) begin
      errors++; $display("FAIL write_keeps_mdatain: got %h want 00000000", a_mdatain);
    end
    run_req(0, 1'b1, 1'b0, 32'h0, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL read_latency: got %0d want 4", lat); end
    checks++;
    if (a_mdatain !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read_data: got %h want deadbeef", a_mdatain);
    end
  endtask

  task automatic test_ws0_back_to_back();
    int lat, t1, t2;
    set_mar(1, 32'h1);
    run_req(1, 1'b0, 1'b1, 32'h1111_1111, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL ws0_write_latency: got %0d want 2", lat); end
    set_mar(1, 32'h2);
    run_req(1, 1'b0, 1'b1, 32'h2222_2222, lat);
    set_mar(1, 32'h1);
    t1 = -1; t2 = -1;
    b_read = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); @(negedge clock);
      b_marin = 1'b0;
      if (b_done === 1'b1) begin
        if (t1 < 0) begin
          t1 = i;
          checks++;
          if (b_mdatain !== 32'h1111_1111) begin
            errors++; $display("FAIL ws0_read1: got %h want 11111111", b_mdatain);
          end
          b_marin = 1'b1; b_bus = 32'h2;
        end else begin
          t2 = i;
          break;
        end
      end
    end
    b_read = 1'b0; b_marin = 1'b0;
    checks++;
    if (t1 !== 2) begin errors++; $display("FAIL ws0_read_latency: got %0d want 2", t1); end
    checks++;
    if (t2 - t1 !== 3) begin errors++; $display("FAIL ws0_spacing: got %0d want 3", t2 - t1); end
    checks++;
    if (b_mdatain !== 32'h2222_2222) begin
      errors++; $display("FAIL ws0_read2: got %h want 22222222", b_mdatain);
    end
  endtask

  task automatic test_illegal();
    int lat;
    set_mar(0, 32'h40);
    run_req(0, 1'b0, 1'b1, 32'h55AA_55AA, lat);
    @(posedge clock); @(negedge clock);
    a_mdr = 32'hFFFF_0000; a_read = 1'b1; a_write = 1'b1;
    @(posedge clock); @(negedge clock);
    checks++;
    if (a_err !== 1'b1 || a_busy !== 1'b0) begin
      errors++; $display("FAIL illegal_err: got err=%b busy=%b want 1 0", a_err, a_busy);
    end
    a_read = 1'b0; a_write = 1'b0;
    @(posedge clock); @(negedge clock);
    checks++;
    if (a_err !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL illegal_pulse: got err=%b busy=%b want 0 0", a_err, a_busy);
    end
    run_req(0, 1'b1, 1'b0, 32'h0, lat);
    checks++;
    if (a_mdatain !== 32'h55AA_55AA) begin
      errors++; $display("FAIL illegal_ram: got %h want 55aa55aa", a_mdatain);
    end
  endtask

  task automatic test_mar_change();
    int lat;
    set_mar(0, 32'h10);
    run_req(0, 1'b0, 1'b1, 32'h1010_1010, lat);
    set_mar(0, 32'h20);
    run_req(0, 1'b0, 1'b1, 32'h2020_2020, lat);
    set_mar(0, 32'h10);
    a_read = 1'b1;
    @(posedge clock); @(negedge clock);
    a_marin = 1'b1; a_bus = 32'h20;
    @(posedge clock); @(negedge clock);
    a_marin = 1'b0;
    lat = -1;
    for (int i = 3; i <= 20; i++) begin
      @(posedge clock); @(negedge clock);
      if (a_done === 1'b1) begin lat = i; break; end
    end
    a_read = 1'b0;
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL marchg_latency: got %0d want 4", lat); end
    checks++;
    if (a_mdatain !== 32'h1010_1010) begin
      errors++; $display("FAIL marchg_data: got %h want 10101010", a_mdatain);
    end
    checks++;
    if (a_mar !== 9'h020) begin errors++; $display("FAIL marchg_mar: got %h want 020", a_mar); end
  endtask

  task automatic test_reset_mid_write();
    int lat, pulses;
    set_mar(0, 32'h30);
    run_req(0, 1'b0, 1'b1, 32'h0BAD_CAFE, lat);
    @(posedge clock); @(negedge clock);
    a_mdr = 32'h1234_5678; a_write = 1'b1;
    @(posedge clock); @(negedge clock);
    a_write = 1'b0;
    clear = 1'b0;
    #1;
    checks++;
    if (a_busy !== 1'b0 || a_mar !== 9'h0 || a_mdatain !== 32'h0) begin
      errors++;
      $display("FAIL midreset_async: got busy=%b mar=%h mdatain=%h want 0 000 00000000",
               a_busy, a_mar, a_mdatain);
    end
    @(negedge clock); @(negedge clock);
    clear = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); @(negedge clock);
      if (a_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL midreset_done: got %0d want 0", pulses); end
    set_mar(0, 32'h30);
    run_req(0, 1'b1, 1'b0, 32'h0, lat);
    checks++;
    if (a_mdatain !== 32'h0BAD_CAFE) begin
      errors++; $display("FAIL midreset_ram: got %h want 0badcafe", a_mdatain);
    end
  endtask

  task automatic test_wrap();
    int lat;
    set_mar(0, 32'h0000_0205);
    checks++;
    if (a_mar !== 9'h005) begin errors++; $display("FAIL wrap_mar: got %h want 005", a_mar); end
    run_req(0, 1'b0, 1'b1, 32'hCAFE_F00D, lat);
    set_mar(0, 32'h0000_0005);
    run_req(0, 1'b1, 1'b0, 32'h0, lat);
    checks++;
    if (a_mdatain !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL wrap_data: got %h want cafef00d", a_mdatain);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_ws0_back_to_back();
    test_illegal();
    test_mar_change();
    test_reset_mid_write();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Memory-side stage directly upstream of the datapath's MDR. Owns the MAR and a word-addressed single-port RAM.
- Services Read/Write requests from the control unit with a configurable wait-state latency.
- Returns read data on Mdatain for MDR capture and raises a one-cycle Done handshake on completion.

Parameters:
ADDR_WIDTH, 9, word address width (512-word memory)
DATA_WIDTH, 32, word width; matches the bus
WAIT_STATES, 2, extra cycles per access (0..15)

Ports:
clock  input  1  system clock, rising-edge
clear  input  1  asynchronous active-low reset
MARin  input  1  load MAR from bus_in[ADDR_WIDTH-1:0]
bus_in  input  DATA_WIDTH  datapath bus (BusMuxOut)
mdr_in  input  DATA_WIDTH  current MDR contents (write data)
Read  input  1  read request, level, sampled in IDLE
Write  input  1  write request, level, sampled in IDLE
Mdatain  output  DATA_WIDTH  read data to MDR
Done  output  1  one-cycle completion pulse
busy  output  1  high whenever state != IDLE
err  output  1  one-cycle pulse on illegal request
mar_q  output  ADDR_WIDTH  MAR value (debug/visibility)

Behaviour:
- Reset (clear=0, async):
  - State=IDLE; MAR, Mdatain, Done, busy, err, wait counter all 0.
  - RAM contents are not cleared.
  - Reset during WAIT/ACCESS aborts the access: no RAM write occurs and no Done is issued.
- MAR:
  - Loads bus_in[ADDR_WIDTH-1:0] on any edge with MARin=1, in any state.
  - The in-flight access uses the address latched at request acceptance, so MAR changes during busy affect only the next access.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - Read XOR Write at edge t0: latch op, addr=MAR, wdata=mdr_in. Go to WAIT with cnt=WAIT_STATES, or go directly to ACCESS if WAIT_STATES=0.
  - Read AND Write together: err=1 for one cycle, stay IDLE, no access.
- WAIT: cnt decrements each edge; transition to ACCESS on the edge where cnt reaches 0.
- ACCESS (one cycle):
  - Read: Mdatain <= RAM[addr] at the exiting edge.
  - Write: RAM[addr] <= wdata at the exiting edge; Mdatain is unchanged.
  - Next state is DONE.
- DONE: Done=1 for exactly this cycle, then IDLE. A request cannot be accepted until the IDLE cycle that follows.
- Latency:
  - Done is high in the cycle after edge t0+WAIT_STATES+1. Example: WAIT_STATES=2, request at edge 0, Done high after edge 3.
  - Back-to-back request spacing is WAIT_STATES+3 cycles minimum.
- Requests while busy are ignored; they are not queued. Read/Write still asserted when IDLE is re-entered start a new access. The control unit must drop the request on Done.
- Mdatain holds its last read value until the next read's ACCESS edge.
- Addresses wrap naturally within ADDR_WIDTH; there are no out-of-range addresses.
- busy is registered and equals (state != IDLE).

Decomposition:
- Shared package mem_pkg: state enum (IDLE, WAIT, ACCESS, DONE), default ADDR_WIDTH/DATA_WIDTH constants, WAIT_STATES maximum (15).
- One sub-module, ram_sp: synchronous single-port RAM with parameters ADDR_WIDTH and DATA_WIDTH. Inputs: clock, we, addr, din. Output: registered dout.
  - mem_controller issues the ram_sp read one cycle early so that dout lands on the ACCESS exit edge.
  - ram_sp has no reset on its array.

Test Plan:
1. Reset then write-read: clear=0→1; MARin with bus_in=0x000000A5; Write with mdr_in=0xDEADBEEF → Done after edge 3, busy high for edges 1–3. Then Read → Mdatain=0xDEADBEEF concurrent with Done.
2. WAIT_STATES=0 build: Read at edge 0 → Done high after edge 1; back-to-back reads of addresses 0x001 and 0x002 are spaced 3 cycles apart.
3. Illegal request: Read=Write=1 in IDLE → err pulse of 1 cycle, busy stays 0, RAM[MAR] unchanged on readback.
4. MAR change mid-access: Read of 0x010 accepted, then MARin with 0x020 during WAIT → data returned is from 0x010; mar_q=0x020 afterward.
5. Reset mid-write: Write of 0x12345678 to 0x030 accepted, clear=0 during WAIT → Done never pulses; after reset, a read of 0x030 returns the prior value, not 0x12345678.
6. Address wrap: bus_in=0x00000205 with MARin → mar_q=0x005; write 0xCAFEF00D, then read via bus_in=0x005 → 0xCAFEF00D.
